// File: rtl/data_memory_responder.sv
// Single-ported word memory answering one load/store at a time after a fixed LATENCY.
// Latency: response valid LATENCY edges after the request handshake, then one bubble cycle.
// Backpressure: response held until responseReady; requestReady low whenever a request is in flight.
module data_memory_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        requestValid,
    output logic        requestReady,
    input  logic [1:0]  requestOperation,
    input  logic [31:0] requestAddress,
    input  logic [31:0] requestWriteData,
    input  logic [3:0]  requestByteEnable,
    output logic        responseValid,
    input  logic        responseReady,
    output logic [31:0] responseReadData,
    output logic        responseError
);
    localparam logic [1:0]  MEM_LOAD    = 2'd1;
    localparam logic [1:0]  MEM_STORE   = 2'd2;
    localparam int          IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);
    localparam logic [3:0]  CNT_LOAD    = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               bubble_q, bubble_d;
    logic               is_store_q, is_store_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rerr_q, rerr_d;
    logic               enter_respond;
    logic               mem_we;
    logic               req_hs;
    logic               req_err;
    logic [31:0]        mem [DEPTH_WORDS];

    assign requestReady     = (state_q == IDLE) && !bubble_q;
    assign req_hs           = requestValid && requestReady;
    assign responseValid    = (state_q == RESPOND);
    assign responseReadData = rdata_q;
    assign responseError    = rerr_q;

    assign req_err = (requestAddress[1:0] != 2'b00)
                  || ({2'b00, requestAddress[31:2]} >= DEPTH_LIMIT)
                  || !((requestOperation == MEM_LOAD) || (requestOperation == MEM_STORE));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bubble_d      = 1'b0;
        is_store_d    = is_store_q;
        err_d         = err_q;
        idx_d         = idx_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        rdata_d       = rdata_q;
        rerr_d        = rerr_q;
        enter_respond = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    is_store_d = (requestOperation == MEM_STORE);
                    err_d      = req_err;
                    idx_d      = requestAddress[IDX_W+1:2];
                    wdata_d    = requestWriteData;
                    be_d       = requestByteEnable;
                    if (LATENCY <= 1) begin
                        state_d       = RESPOND;
                        enter_respond = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d       = RESPOND;
                    cnt_d         = 4'd0;
                    enter_respond = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESPOND: begin
                if (responseReady) begin
                    state_d  = IDLE;
                    bubble_d = 1'b1;
                    rdata_d  = 32'd0;
                    rerr_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        // The *_d copies are used so the single-cycle path sees the request being accepted now.
        if (enter_respond) begin
            rerr_d  = err_d;
            rdata_d = (!err_d && !is_store_d) ? mem[idx_d] : 32'd0;
        end
    end

    assign mem_we = enter_respond && is_store_d && !err_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            bubble_q   <= 1'b1;
            is_store_q <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            rdata_q    <= 32'd0;
            rerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bubble_q   <= bubble_d;
            is_store_q <= is_store_d;
            err_q      <= err_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            rdata_q    <= rdata_d;
            rerr_q     <= rerr_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be_d[i]) mem[idx_d][8*i +: 8] <= wdata_d[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: directed cases plus randomized traffic against a word-array model.
module tb_data_memory_responder;
    localparam int DEPTH = 1024;
    localparam logic [1:0] OP_NONE = 2'd0, OP_LOAD = 2'd1, OP_STORE = 2'd2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        requestValid, requestReady;
    logic [1:0]  requestOperation;
    logic [31:0] requestAddress, requestWriteData;
    logic [3:0]  requestByteEnable;
    logic        responseValid, responseReady, responseError;
    logic [31:0] responseReadData;

    logic        rv_b, rdy_b, vld_b, rr_b, err_b;
    logic [1:0]  op_b;
    logic [31:0] addr_b, wd_b, rd_b;
    logic [3:0]  be_b;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] model [64];

    always #5 clock = ~clock;

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .requestValid(requestValid), .requestReady(requestReady),
        .requestOperation(requestOperation), .requestAddress(requestAddress),
        .requestWriteData(requestWriteData), .requestByteEnable(requestByteEnable),
        .responseValid(responseValid), .responseReady(responseReady),
        .responseReadData(responseReadData), .responseError(responseError)
    );

    data_memory_responder #(.DEPTH_WORDS(64), .LATENCY(1)) u_dut_l1 (
        .clock(clock), .reset_n(reset_n),
        .requestValid(rv_b), .requestReady(rdy_b),
        .requestOperation(op_b), .requestAddress(addr_b),
        .requestWriteData(wd_b), .requestByteEnable(be_b),
        .responseValid(vld_b), .responseReady(rr_b),
        .responseReadData(rd_b), .responseError(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction on the LATENCY=2 instance; hold = cycles of responseReady=0 in RESPOND.
    task automatic xact(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int hold, input string tag,
                        output logic [31:0] got_d, output logic got_e);
        logic [31:0] exp_d;
        logic        exp_e;
        int          n;
        exp_e = (addr % 4 != 0) || ((addr / 4) >= DEPTH) || !(op == OP_LOAD || op == OP_STORE);
        exp_d = (!exp_e && op == OP_LOAD) ? model[addr / 4] : 32'd0;
        n = 0;
        while (!requestReady && n < 50) begin
            @(posedge clock); #1; n++;
        end
        chk({tag, "_reqready"}, requestReady, 1);
        requestValid = 1'b1; requestOperation = op; requestAddress = addr;
        requestWriteData = wd; requestByteEnable = be;
        responseReady = (hold == 0);
        @(posedge clock); #1;
        requestValid = 1'b0;
        requestOperation = 2'($urandom); requestAddress = $urandom;
        requestWriteData = $urandom; requestByteEnable = 4'($urandom);
        if (!exp_e && op == OP_STORE) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) model[addr / 4] = (model[addr / 4] & ~(32'hFF << (8 * i)))
                                           | (wd & (32'hFF << (8 * i)));
            end
        end
        n = 1;
        while (!responseValid && n < 50) begin
            @(posedge clock); #1; n++;
        end
        chk({tag, "_latency"}, n, 2);
        got_d = responseReadData;
        got_e = responseError;
        chk({tag, "_data"}, responseReadData, exp_d);
        chk({tag, "_err"}, responseError, exp_e);
        for (int h = 0; h < hold; h++) begin
            @(posedge clock); #1;
            chk({tag, "_hold_vld"}, responseValid, 1);
            chk({tag, "_hold_data"}, responseReadData, exp_d);
            chk({tag, "_hold_err"}, responseError, exp_e);
            chk({tag, "_hold_reqready"}, requestReady, 0);
        end
        responseReady = 1'b1;
        @(posedge clock); #1;
        chk({tag, "_bubble_reqready"}, requestReady, 0);
        chk({tag, "_bubble_vld"}, responseValid, 0);
        chk({tag, "_bubble_data"}, responseReadData, 0);
        @(posedge clock); #1;
        chk({tag, "_post_reqready"}, requestReady, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] gd, old40;
        logic        ge;
        logic [1:0]  op;
        logic [31:0] addr;
        int          r, sel, last, hs_cnt;
        logic        pend;

        reset_n = 1'b0; requestValid = 1'b0; requestOperation = OP_NONE;
        requestAddress = 32'd0; requestWriteData = 32'd0; requestByteEnable = 4'd0;
        responseReady = 1'b1;
        rv_b = 1'b0; op_b = OP_LOAD; addr_b = 32'd0; wd_b = 32'd0; be_b = 4'd0; rr_b = 1'b1;
        #12;
        chk("rst_vld", responseValid, 0);
        chk("rst_reqready", requestReady, 0);
        chk("rst_data", responseReadData, 0);
        chk("rst_err", responseError, 0);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;
        chk("rst_release_reqready", requestReady, 1);

        for (int w = 0; w < 64; w++) xact(OP_STORE, 32'(w * 4), $urandom, 4'hF, 0, "preload", gd, ge);

        xact(OP_STORE, 32'h10, 32'hDEADBEEF, 4'hF, 0, "st10", gd, ge);
        xact(OP_LOAD, 32'h10, 32'h0, 4'h0, 0, "ld10", gd, ge);
        chk("ld10_literal", gd, 32'hDEADBEEF);

        xact(OP_STORE, 32'h20, 32'h11223344, 4'hF, 0, "st20_full", gd, ge);
        xact(OP_STORE, 32'h20, 32'hAABBCCDD, 4'b0101, 0, "st20_part", gd, ge);
        xact(OP_LOAD, 32'h20, 32'h0, 4'hF, 0, "ld20", gd, ge);
        chk("ld20_literal", gd, 32'h11BB33DD);
        xact(OP_STORE, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, "st20_nobe", gd, ge);
        xact(OP_LOAD, 32'h20, 32'h0, 4'h0, 0, "ld20_nobe", gd, ge);

        xact(OP_LOAD, 32'h13, 32'h0, 4'hF, 0, "ld_misaligned", gd, ge);
        chk("ld_misaligned_err_literal", ge, 1);
        xact(OP_STORE, 32'(4 * DEPTH), 32'hCAFEF00D, 4'hF, 0, "st_oob", gd, ge);
        xact(OP_LOAD, 32'h0, 32'h0, 4'h0, 0, "ld0_after_oob", gd, ge);
        xact(OP_NONE, 32'h8, 32'h0, 4'hF, 0, "op_none", gd, ge);
        chk("op_none_err_literal", ge, 1);
        xact(2'b11, 32'h8, 32'h0, 4'hF, 0, "op_11", gd, ge);

        xact(OP_LOAD, 32'h10, 32'h0, 4'h0, 5, "backpressure", gd, ge);

        // Reset pulse while a store sits in WAIT.
        old40 = model[16];
        requestValid = 1'b1; requestOperation = OP_STORE; requestAddress = 32'h40;
        requestWriteData = ~old40; requestByteEnable = 4'hF;
        @(posedge clock); #1;
        requestValid = 1'b0;
        chk("midrst_in_wait_vld", responseValid, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_vld", responseValid, 0);
        chk("midrst_data", responseReadData, 0);
        chk("midrst_err", responseError, 0);
        chk("midrst_reqready", requestReady, 0);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;
        chk("midrst_release_reqready", requestReady, 1);
        xact(OP_LOAD, 32'h40, 32'h0, 4'h0, 0, "ld40_after_rst", gd, ge);
        chk("ld40_old_value", gd, old40);

        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            op = (r < 4) ? OP_LOAD : (r < 8) ? OP_STORE : (r == 8) ? OP_NONE : 2'b11;
            sel = $urandom_range(0, 9);
            addr = 32'($urandom_range(0, 63)) * 4;
            if (sel == 0) addr = addr | 32'($urandom_range(1, 3));
            if (sel == 1) addr = 32'(4 * DEPTH) + 32'($urandom_range(0, 1000)) * 4;
            xact(op, addr, $urandom, 4'($urandom), $urandom_range(0, 3), "rand", gd, ge);
        end
        for (int w = 0; w < 64; w += 7) xact(OP_LOAD, 32'(w * 4), 32'h0, 4'h0, 0, "sweep", gd, ge);

        // LATENCY=1 instance with requestValid held high: accept, respond, bubble.
        rv_b = 1'b1; rr_b = 1'b1; op_b = OP_LOAD; addr_b = 32'h0;
        last = -1; hs_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            pend = rv_b && rdy_b;
            @(posedge clock); #1;
            if (pend) begin
                chk("l1_vld_after_accept", vld_b, 1);
                chk("l1_err", err_b, 0);
                chk("l1_reqready_low", rdy_b, 0);
                if (last >= 0) chk("l1_spacing", c - last, 3);
                last = c;
                hs_cnt++;
            end
        end
        chk("l1_handshake_count", hs_cnt, 5);
        rv_b = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
